// File: rtl/ts_tx_serializer_pkg.sv
// ts_tx_serializer_pkg: shared constants, FSM state type and K-symbol helper for the TS transmit serializer.
package ts_tx_serializer_pkg;
    localparam int TS_W  = 128;
    localparam int SYM_W = 8;
    localparam int N_SYM = TS_W / SYM_W;
    localparam logic [SYM_W-1:0] COM    = 8'hBC;
    localparam logic [SYM_W-1:0] PADG12 = 8'hF7;
    typedef enum logic {IDLE, SEND} state_e;
    // COM is only a K-character in the first slot, PAD only in the link/lane number slots
    function automatic logic sym_is_k(input logic [3:0] idx, input logic [SYM_W-1:0] sym);
        return (idx == 4'd0 && sym == COM) || ((idx == 4'd1 || idx == 4'd2) && sym == PADG12);
    endfunction
endpackage

// File: rtl/ts_tx_serializer_if.sv
// ts_tx_serializer_if: generator-side TS write/back-pressure and PHY-side symbol handshake.
//  ts_valid/ts          generator -> serializer, 128b ordered set
//  ts_tx_fifo_full      serializer -> generator back-pressure
//  tx_sym/_k/_valid     serializer -> PHY symbol beat
//  tx_sym_ready         PHY -> serializer acceptance
interface ts_tx_serializer_if;
    logic         ts_valid;
    logic [127:0] ts;
    logic         ts_tx_fifo_full;
    logic [7:0]   tx_sym;
    logic         tx_sym_k;
    logic         tx_sym_valid;
    logic         tx_sym_ready;
    modport master (output ts_valid, ts, tx_sym_ready,
                    input  ts_tx_fifo_full, tx_sym, tx_sym_k, tx_sym_valid);
    modport slave  (input  ts_valid, ts, tx_sym_ready,
                    output ts_tx_fifo_full, tx_sym, tx_sym_k, tx_sym_valid);
endinterface

// File: rtl/ts_tx_serializer_fifo.sv
// ts_fifo: DEPTH x W synchronous FIFO with clear and next-cycle occupancy output.
//  clk/rst      clock, sync active-high reset
//  clr_i        drop all entries
//  push_i/din_i write (caller guarantees space or same-cycle pop)
//  pop_i/dout_o read head (dout_o is the current head)
//  empty_o/full_o current occupancy flags
//  count_d_o    occupancy after this cycle's push/pop/clear
module ts_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [W-1:0]            din_i,
    output logic [W-1:0]            dout_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [$clog2(DEPTH):0]  count_d_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    assign count_d_o = clr_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
    assign empty_o   = count_q == '0;
    assign full_o    = count_q == CW'(DEPTH);
    assign dout_o    = mem_q[rd_q];
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i) rd_q <= rd_q + AW'(1);
            count_q <= count_d_o;
        end
    end
endmodule

// File: rtl/ts_tx_serializer.sv
// ts_tx_serializer: buffers 128b TS1/TS2 ordered sets and serializes them into 16 symbol beats.
//  clk/rst        clock, sync active-high reset
//  flush_i        abandon current TS and drop all buffered ones
//  bus (slave)    ts_valid/ts in, ts_tx_fifo_full out, tx_sym/_k/_valid out, tx_sym_ready in
//  ts_sent_cnt_o  saturating count of fully transmitted TSs
//  ts_ovf_o       sticky: a TS arrived with no free FIFO entry
module ts_tx_serializer
    import ts_tx_serializer_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int AFULL_MARGIN = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    ts_tx_serializer_if.slave bus,
    output logic [CNT_W-1:0]  ts_sent_cnt_o,
    output logic              ts_ovf_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    state_e          state_q;
    logic [TS_W-1:0] shift_q, head;
    logic [3:0]      idx_q;
    logic            k_q, full_q, ovf_q, empty, fifo_full, push, pop, accept, last;
    logic [CW-1:0]   count_d;
    logic [CNT_W-1:0] cnt_q;
    assign accept = state_q == SEND && bus.tx_sym_ready;
    assign last   = accept && idx_q == 4'(N_SYM - 1);
    // refill on the last accepted beat so consecutive TSs leave no bubble
    assign pop    = !flush_i && !empty && (state_q == IDLE || last);
    // a same-cycle pop frees the slot, so a write at full occupancy still lands
    assign push   = !flush_i && bus.ts_valid && (!fifo_full || pop);
    ts_fifo #(.DEPTH(DEPTH), .W(TS_W)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (flush_i),
        .push_i   (push),
        .pop_i    (pop),
        .din_i    (bus.ts),
        .dout_o   (head),
        .empty_o  (empty),
        .full_o   (fifo_full),
        .count_d_o(count_d)
    );
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            k_q     <= 1'b0;
            full_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            full_q <= count_d >= CW'(DEPTH - AFULL_MARGIN);
            if (pop) begin
                shift_q <= head;
                idx_q   <= '0;
                k_q     <= sym_is_k(4'd0, head[TS_W-1 -: SYM_W]);
                state_q <= SEND;
            end else if (accept) begin
                shift_q <= shift_q << SYM_W;
                idx_q   <= idx_q + 4'd1;
                k_q     <= sym_is_k(idx_q + 4'd1, shift_q[TS_W-SYM_W-1 -: SYM_W]);
                if (last) state_q <= IDLE;
            end
            if (last && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else if (bus.ts_valid && !flush_i && !push) ovf_q <= 1'b1;
    end
    assign bus.ts_tx_fifo_full = full_q;
    assign bus.tx_sym          = shift_q[TS_W-1 -: SYM_W];
    assign bus.tx_sym_k        = k_q;
    assign bus.tx_sym_valid    = state_q == SEND;
    assign ts_sent_cnt_o       = cnt_q;
    assign ts_ovf_o            = ovf_q;
endmodule

// File: tb/tb_ts_tx_serializer.sv
// tb_ts_tx_serializer: scoreboard bench for the TS transmit serializer.
module tb_ts_tx_serializer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] cnt;
    logic        ovf;
    ts_tx_serializer_if bus();
    ts_tx_serializer #(.DEPTH(4), .AFULL_MARGIN(1), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .bus          (bus.slave),
        .ts_sent_cnt_o(cnt),
        .ts_ovf_o     (ovf)
    );
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] w;
        logic [15:0]  km;
    } vec_t;
    vec_t        vecs[5];
    logic [8:0]  sb[$];
    int n_cmp = 0, n_err = 0;
    int cyc = 0, acc = 0, first_acc = -1, last_acc = -1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] poll(input logic [7:0] tail);
        return {8'hBC, 8'hF7, 8'hF7, 8'hFF, 8'h02, 8'h00, {9{8'h4A}}, tail};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ts(input logic [127:0] w, input logic [15:0] km, input bit exp);
        if (exp)
            for (int i = 0; i < 16; i++) sb.push_back({km[i], w[127-8*i -: 8]});
        bus.ts_valid = 1'b1;
        bus.ts = w;
        tick();
        bus.ts_valid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
        end
        tick();
    endtask

    task automatic quiet(input string name, input int cycles);
        int vc = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.tx_sym_valid) vc++;
        end
        chk(name, vc, 0);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst && !flush && bus.tx_sym_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL extra_beat: got %0h with no beat expected", {bus.tx_sym_k, bus.tx_sym});
            end else begin
                chk(bus.tx_sym_ready ? "beat" : "hold", {bus.tx_sym_k, bus.tx_sym}, sb[0]);
                if (bus.tx_sym_ready) begin
                    void'(sb.pop_front());
                    acc++;
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0;
        vecs[0] = '{poll(8'h4A), 16'h0007};
        vecs[1] = '{128'h0, 16'h0000};
        vecs[2] = '{{8'h00, 8'hBC, 8'hF7, 104'h0}, 16'h0004};
        vecs[3] = '{{8'hBC, 8'h01, 8'h02, 8'hF7, {12{8'hF7}}}, 16'h0001};
        vecs[4] = '{{8'hF7, 8'hF7, 8'hBC, {13{8'h55}}}, 16'h0002};
        bus.ts_valid = 1'b0;
        bus.ts = '0;
        bus.tx_sym_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_valid", bus.tx_sym_valid, 0);
        chk("rst_sym", bus.tx_sym, 0);
        chk("rst_k", bus.tx_sym_k, 0);
        chk("rst_full", bus.ts_tx_fifo_full, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            write_ts(vecs[i].w, vecs[i].km, 1'b1);
            @(negedge clk);
            chk("lat_n1_valid", bus.tx_sym_valid, 0);
            tick();
            @(negedge clk);
            chk("lat_n2_valid", bus.tx_sym_valid, 1);
            chk("lat_sym0", bus.tx_sym, vecs[i].w[127:120]);
            tick();
            drain(40);
            chk("vec_cnt", cnt, i + 1);
        end

        a0 = acc;
        first_acc = -1;
        for (int i = 1; i <= 3; i++) write_ts(poll(8'(i)), 16'h0007, 1'b1);
        drain(100);
        chk("b2b_beats", acc - a0, 48);
        chk("b2b_span", last_acc - first_acc + 1, 48);
        chk("b2b_cnt", cnt, 8);

        bus.tx_sym_ready = 1'b0;
        write_ts(poll(8'h10), 16'h0007, 1'b1);
        tick();
        tick();
        write_ts(poll(8'h11), 16'h0007, 1'b1);
        write_ts(poll(8'h12), 16'h0007, 1'b1);
        @(negedge clk);
        chk("full_after_2", bus.ts_tx_fifo_full, 0);
        write_ts(poll(8'h13), 16'h0007, 1'b1);
        @(negedge clk);
        chk("full_after_3", bus.ts_tx_fifo_full, 1);
        write_ts(poll(8'h14), 16'h0007, 1'b1);
        @(negedge clk);
        chk("full_after_4", bus.ts_tx_fifo_full, 1);
        chk("ovf_after_4", ovf, 0);
        write_ts(poll(8'h15), 16'h0007, 1'b0);
        @(negedge clk);
        chk("ovf_after_5", ovf, 1);
        bus.tx_sym_ready = 1'b1;
        tick();
        drain(200);
        chk("ovf_cnt", cnt, 13);
        chk("ovf_sticky", ovf, 1);

        write_ts(poll(8'h20), 16'h0007, 1'b1);
        for (int n = 0; sb.size() != 0 && n < 80; n++) begin
            bus.tx_sym_ready = n[0];
            tick();
        end
        bus.tx_sym_ready = 1'b1;
        drain(5);
        chk("toggle_cnt", cnt, 14);

        for (int i = 0; i < 3; i++) write_ts(poll(8'(8'h30 + i)), 16'h0007, 1'b1);
        repeat (6) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_valid", bus.tx_sym_valid, 0);
        chk("flush_full", bus.ts_tx_fifo_full, 0);
        chk("flush_cnt", cnt, 0);
        chk("flush_ovf_kept", ovf, 1);
        quiet("flush_quiet", 30);
        tick();

        write_ts(poll(8'h66), 16'h0007, 1'b1);
        repeat (4) tick();
        rst = 1'b1;
        bus.ts_valid = 1'b1;
        bus.ts = poll(8'h77);
        tick();
        sb.delete();
        @(negedge clk);
        chk("rst2_valid", bus.tx_sym_valid, 0);
        chk("rst2_sym", bus.tx_sym, 0);
        chk("rst2_k", bus.tx_sym_k, 0);
        chk("rst2_full", bus.ts_tx_fifo_full, 0);
        chk("rst2_cnt", cnt, 0);
        chk("rst2_ovf", ovf, 0);
        rst = 1'b0;
        bus.ts_valid = 1'b0;
        quiet("rst2_quiet", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
